// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - two-requester byte handshake into the UART TX arbiter
// Master is the requester side; slave is the arbiter.
interface uart_tx_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              req0_valid;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART 8N1 transmit line
// Accepts one byte per frame from either requester and serializes it LSB first.
module uart_tx_arbiter #(
   parameter int CLK_DIV = 217,
   parameter int DATA_W  = 8
) (
   input  logic             clk_in,
   input  logic             reset,
   uart_tx_arbiter_if.slave req,
   output logic             tx,
   output logic             busy,
   output logic             grant_id,
   output logic             frame_done
);
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shift;
   logic              last_grant;
   logic              idle;
   logic              take0;
   logic              take1;
   logic              bit_end;

   // The requester that did not win last time has priority on a tie.
   assign idle           = (state == IDLE);
   assign req.req0_ready = idle & (!req.req1_valid | last_grant);
   assign req.req1_ready = idle & (!req.req0_valid | !last_grant);
   assign take0          = req.req0_valid & req.req0_ready;
   assign take1          = req.req1_valid & req.req1_ready;
   assign bit_end        = (bit_cnt == CNT_LAST);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         last_grant <= 1'b1;
         tx         <= 1'b1;
         busy       <= 1'b0;
         grant_id   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (take0 || take1) begin
                  shift      <= take0 ? req.req0_data : req.req1_data;
                  grant_id   <= take1;
                  last_grant <= take1;
                  state      <= START;
                  busy       <= 1'b1;
                  tx         <= 1'b0;
                  bit_cnt    <= '0;
                  bit_idx    <= '0;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= DATA;
                  tx      <= shift[0];
                  shift   <= shift >> 1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  bit_cnt    <= '0;
                  state      <= IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
// Cycle k counts negedges after the accept edge; inputs change and outputs are sampled on negedges.
module tb_uart_tx_arbiter;
   localparam int D = 4;

   logic clk_in;
   logic reset;
   logic tx;
   logic busy;
   logic grant_id;
   logic frame_done;

   int n_cmp;
   int n_fail;

   uart_tx_arbiter_if bus ();

   uart_tx_arbiter #(.CLK_DIV(D), .DATA_W(8)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .req        (bus),
      .tx         (tx),
      .busy       (busy),
      .grant_id   (grant_id),
      .frame_done (frame_done)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Expected line level k cycles after the accept edge.
   function automatic logic exp_tx(input logic [7:0] b, input int k);
      if (k >= 1 && k <= D)
         return 1'b0;
      else if (k > D && k <= 9 * D)
         return b[(k - D - 1) / D];
      else
         return 1'b1;
   endfunction

   task automatic do_reset();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clk_in);
      reset = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      reset = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_data  = 8'h00;
      bus.req1_data  = 8'h00;
      reset = 1'b1;
      #12;
      n_cmp++;
      if ({tx, busy, frame_done, grant_id} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_outputs: tx/busy/fd/gid=%b required 1000", {tx, busy, frame_done, grant_id});
      end
      @(negedge clk_in);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         n_cmp++;
         if ({tx, busy, frame_done, bus.req0_ready, bus.req1_ready} !== 5'b10011) begin
            n_fail++;
            $display("FAIL idle_after_reset: tx/busy/fd/r0/r1=%b required 10011",
                     {tx, busy, frame_done, bus.req0_ready, bus.req1_ready});
         end
      end
   endtask

   task automatic test_single_a5();
      @(negedge clk_in);
      bus.req0_data  = 8'hA5;
      bus.req0_valid = 1'b1;
      #1;
      n_cmp++;
      if (bus.req0_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL a5_ready: req0_ready=%b required 1", bus.req0_ready);
      end
      for (int k = 1; k <= 41; k++) begin
         @(negedge clk_in);
         bus.req0_valid = 1'b0;
         n_cmp++;
         if (tx !== exp_tx(8'hA5, k) || busy !== (k <= 40) || frame_done !== (k == 41)) begin
            n_fail++;
            $display("FAIL a5_cycle%0d: tx/busy/fd=%b%b%b required %b%b%b", k, tx, busy, frame_done,
                     exp_tx(8'hA5, k), (k <= 40), (k == 41));
         end
         if (k == 1) begin
            n_cmp++;
            if (grant_id !== 1'b0) begin
               n_fail++;
               $display("FAIL a5_grant: grant_id=%b required 0", grant_id);
            end
         end
      end
   endtask

   task automatic test_alternate();
      logic [7:0] b;
      logic       id;
      do_reset();
      bus.req0_data  = 8'h55;
      bus.req1_data  = 8'h0F;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int f = 0; f < 4; f++) begin
         id = f[0];
         b  = id ? 8'h0F : 8'h55;
         #1;
         n_cmp++;
         if (bus.req0_ready !== !id || bus.req1_ready !== id) begin
            n_fail++;
            $display("FAIL alt_ready_f%0d: r0/r1=%b%b required %b%b", f, bus.req0_ready, bus.req1_ready, !id, id);
         end
         for (int k = 1; k <= 41; k++) begin
            @(negedge clk_in);
            if (k == 41 && f == 3) begin
               bus.req0_valid = 1'b0;
               bus.req1_valid = 1'b0;
            end
            n_cmp++;
            if (tx !== exp_tx(b, k) || frame_done !== (k == 41)) begin
               n_fail++;
               $display("FAIL alt_f%0d_c%0d: tx/fd=%b%b required %b%b", f, k, tx, frame_done, exp_tx(b, k), (k == 41));
            end
            if (k <= 40) begin
               n_cmp++;
               if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || grant_id !== id) begin
                  n_fail++;
                  $display("FAIL alt_busy_f%0d_c%0d: r0/r1/gid=%b%b%b required 00%b", f, k,
                           bus.req0_ready, bus.req1_ready, grant_id, id);
               end
            end
         end
      end
      @(negedge clk_in);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL alt_end_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk_in);
      bus.req1_data  = 8'h00;
      bus.req1_valid = 1'b1;
      for (int f = 0; f < 3; f++) begin
         #1;
         n_cmp++;
         if (bus.req1_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept_f%0d: r1/busy=%b%b required 10", f, bus.req1_ready, busy);
         end
         for (int k = 1; k <= 41; k++) begin
            @(negedge clk_in);
            if (k == 41 && f == 2) bus.req1_valid = 1'b0;
            n_cmp++;
            if (tx !== exp_tx(8'h00, k) || busy !== (k <= 40) || frame_done !== (k == 41)) begin
               n_fail++;
               $display("FAIL b2b_f%0d_c%0d: tx/busy/fd=%b%b%b required %b%b%b", f, k, tx, busy, frame_done,
                        exp_tx(8'h00, k), (k <= 40), (k == 41));
            end
            if (k <= 40) begin
               n_cmp++;
               if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || grant_id !== 1'b1) begin
                  n_fail++;
                  $display("FAIL b2b_busy_f%0d_c%0d: r0/r1/gid=%b%b%b required 001", f, k,
                           bus.req0_ready, bus.req1_ready, grant_id);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int fd_seen;
      bool_wait: begin end
      @(negedge clk_in);
      bus.req0_data  = 8'hA5;
      bus.req0_valid = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk_in);
         bus.req0_valid = 1'b0;
      end
      n_cmp++;
      if (tx !== exp_tx(8'hA5, 18) || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_before: tx/busy=%b%b required %b1", tx, busy, exp_tx(8'hA5, 18));
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: tx/busy/fd=%b%b%b required 100", tx, busy, frame_done);
      end
      @(negedge clk_in);
      reset   = 1'b0;
      fd_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_in);
         if (frame_done) fd_seen++;
      end
      n_cmp++;
      if (fd_seen !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_no_done: frame_done pulses=%0d busy=%b required 0 0", fd_seen, busy);
      end
      bus.req0_data  = 8'h3C;
      bus.req1_data  = 8'hC3;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      n_cmp++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_tie_ready: r0/r1=%b%b required 10", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk_in);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      n_cmp++;
      if (grant_id !== 1'b0 || tx !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_regrant: gid/tx/busy=%b%b%b required 001", grant_id, tx, busy);
      end
      fd_seen = 0;
      for (int i = 0; i < 60 && fd_seen == 0; i++) begin
         @(negedge clk_in);
         if (frame_done) fd_seen = 1;
      end
      n_cmp++;
      if (fd_seen !== 1) begin
         n_fail++;
         $display("FAIL mid_regrant_done: frame_done seen=%0d required 1 within 60 cycles", fd_seen);
      end
   endtask

   task automatic test_ignored_valid();
      int fd_seen;
      @(negedge clk_in);
      bus.req1_data  = 8'h3C;
      bus.req1_valid = 1'b1;
      fd_seen = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk_in);
         bus.req1_valid = 1'b0;
         bus.req0_valid = (k == 10);
         bus.req0_data  = 8'hFF;
         if (frame_done) fd_seen++;
         if (k == 20) begin
            n_cmp++;
            if (tx !== exp_tx(8'h3C, 20) || grant_id !== 1'b1) begin
               n_fail++;
               $display("FAIL ign_mid: tx/gid=%b%b required %b1", tx, grant_id, exp_tx(8'h3C, 20));
            end
         end
      end
      n_cmp++;
      if (fd_seen !== 1 || busy !== 1'b0 || tx !== 1'b1) begin
         n_fail++;
         $display("FAIL ign_count: frames=%0d busy=%b tx=%b required 1 0 1", fd_seen, busy, tx);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b0;
      test_reset();
      test_single_a5();
      test_alternate();
      test_back_to_back();
      test_reset_mid_frame();
      test_ignored_valid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
